model_config_mem: RTL
=====================

MODEL_CONFIG_MEM -- requirements
Module: model_config_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of 32-bit config words, power of two, 4..1024.
REQ-002 SHALL have parameter AW, default 6: word-index width used internally, equal to log2(DEPTH).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port host_wr_valid_i  in  1  host write request.
REQ-007 SHALL have port host_wr_ready_o  out  1  write accepted this cycle.
REQ-008 SHALL have port host_wr_addr_i  in  32  word index.
REQ-009 SHALL have port host_wr_data_i  in  32  write data.
REQ-010 SHALL have port host_wr_err_o  out  1  one-cycle pulse on an out-of-range write.
REQ-011 SHALL have port host_commit_i  in  1  pulse that freezes the config.
REQ-012 SHALL have port host_unlock_i  in  1  pulse that invalidates the config.
REQ-013 SHALL have port config_mem_addr_i  in  32  scheduler read word index.
REQ-014 SHALL have port config_mem_read_valid_i  in  1  scheduler read request.
REQ-015 SHALL have port config_mem_read_data_o  out  32  read data.
REQ-016 SHALL have port config_mem_read_ack_o  out  1  read response strobe.
REQ-017 SHALL have port config_mem_read_err_o  out  1  read response error, qualified by ack.
REQ-018 SHALL have port npu_capability_o  out  32  capability word.
REQ-019 SHALL have port in_pipeline_cim_capability_o  out  32  capability word.
REQ-020 SHALL have port valid_words_o  out  AW+1  highest written index plus 1.
REQ-021 SHALL have port state_o  out  2  current state.

Function
REQ-022 SHALL implement states EMPTY=0, LOADING=1, READY=2; code 3 is unreachable and SHALL decode as EMPTY.
REQ-023 SHALL drive host_wr_ready_o = host_wr_valid_i && state!=READY; writes in READY are stalled, not dropped.
REQ-024 On an accepted write with addr<DEPTH: SHALL store the word and set valid_words = max(valid_words, addr+1).
REQ-025 On an accepted write with addr>=DEPTH: SHALL discard the data and pulse host_wr_err_o the next cycle.
REQ-026 SHALL transition EMPTY->LOADING on any accepted write, including out-of-range writes.
REQ-027 SHALL transition LOADING->READY on host_commit_i and latch npu_capability_o=word[0] and in_pipeline_cim_capability_o=word[1]; commit in EMPTY or READY SHALL be ignored.
REQ-028 When a write and a commit occur in the same cycle in LOADING, the write SHALL land first and capability latching SHALL see the new data (bypass).
REQ-029 SHALL transition READY->EMPTY on host_unlock_i, clearing valid_words and both capability outputs; array contents are not cleared; unlock in other states SHALL be ignored.
REQ-030 Read latency SHALL be exactly 1 cycle: config_mem_read_ack_o=1 in the cycle after config_mem_read_valid_i, with no back-pressure.
REQ-031 A read SHALL be an error (data 0, err 1) if state!=READY at request time or addr>=valid_words; otherwise data=word[addr] and err=0.
REQ-032 config_mem_read_data_o and config_mem_read_err_o SHALL be 0 whenever ack is 0.
REQ-033 A read coinciding with unlock SHALL be served from pre-unlock state; a read coinciding with commit SHALL error.
REQ-034 Back-to-back reads every cycle SHALL each produce one ack at full throughput.

Reset
REQ-035 On rst_i: state=EMPTY; valid_words=0; capabilities=0; host_wr_err_o, config_mem_read_ack_o, config_mem_read_err_o and config_mem_read_data_o SHALL be 0.
REQ-036 A request in the reset cycle SHALL yield no response; the array is not initialised.

Structure
REQ-037 State encodings SHALL live in the shared define include alongside the scheduler's state codes; capability word indices 0/1 SHALL be named constants there.
REQ-038 The storage array SHALL be one sub-module, config_word_ram: 1W1R, synchronous read, no reset.

Verification
REQ-039 Write idx0=0xA5, idx1=0x3C, idx5=0x77, then commit -> state 2, valid_words 6, npu_capability_o 0xA5, cim 0x3C.
REQ-040 In READY, read idx5 then idx6 on consecutive cycles -> acks on the next 2 cycles: 0x77/err0, then 0/err1.
REQ-041 Write idx 64 with DEPTH=64 -> accepted, host_wr_err_o pulse, state 1, valid_words 0.
REQ-042 Write idx0=0x11 with commit in the same cycle -> npu_capability_o=0x11 and state 2 the next cycle.
REQ-043 In READY, write valid for 3 cycles -> ready 0 throughout; then unlock -> state 0, capabilities 0, and the held write is accepted the following cycle.
REQ-044 Read issued in LOADING, with rst_i asserted the next cycle -> no ack and all outputs 0.

Source files
------------

// File: rtl/model_config_mem_pkg.sv
// Shared constants for the model configuration memory.
//   - FSM state codes (also decoded by the scheduler side)
//   - indices of the capability words inside the config array
//   - decode_state(): maps the unused state code onto EMPTY
package model_config_mem_pkg;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  localparam int unsigned CAP_NPU_IDX = 0;  // word holding npu_capability
  localparam int unsigned CAP_CIM_IDX = 1;  // word holding in_pipeline_cim_capability
  localparam int unsigned NUM_CAPS    = 2;

  // Code 3 is never produced, but anything that reads the state register
  // treats it as EMPTY so a corrupted register falls back to a safe state.
  function automatic logic [1:0] decode_state(input logic [1:0] s);
    return (s == 2'd3) ? ST_EMPTY : s;
  endfunction

endpackage

// File: rtl/model_config_mem_if.sv
// Bus bundle between the host / scheduler side and model_config_mem.
//   host write channel : host_wr_valid_i/ready_o/addr_i/data_i/err_o
//   control pulses     : host_commit_i, host_unlock_i
//   scheduler read     : config_mem_addr_i, config_mem_read_valid_i,
//                        config_mem_read_data_o/ack_o/err_o
//   status             : npu_capability_o, in_pipeline_cim_capability_o,
//                        valid_words_o (AW+1 bits), state_o
// slave = memory side, master = host/scheduler side.
interface model_config_mem_if #(
  parameter int AW = 6
);
  logic          host_wr_valid_i;
  logic          host_wr_ready_o;
  logic [31:0]   host_wr_addr_i;
  logic [31:0]   host_wr_data_i;
  logic          host_wr_err_o;
  logic          host_commit_i;
  logic          host_unlock_i;
  logic [31:0]   config_mem_addr_i;
  logic          config_mem_read_valid_i;
  logic [31:0]   config_mem_read_data_o;
  logic          config_mem_read_ack_o;
  logic          config_mem_read_err_o;
  logic [31:0]   npu_capability_o;
  logic [31:0]   in_pipeline_cim_capability_o;
  logic [AW:0]   valid_words_o;
  logic [1:0]    state_o;

  modport slave (
    input  host_wr_valid_i, host_wr_addr_i, host_wr_data_i,
    input  host_commit_i, host_unlock_i,
    input  config_mem_addr_i, config_mem_read_valid_i,
    output host_wr_ready_o, host_wr_err_o,
    output config_mem_read_data_o, config_mem_read_ack_o, config_mem_read_err_o,
    output npu_capability_o, in_pipeline_cim_capability_o,
    output valid_words_o, state_o
  );

  modport master (
    output host_wr_valid_i, host_wr_addr_i, host_wr_data_i,
    output host_commit_i, host_unlock_i,
    output config_mem_addr_i, config_mem_read_valid_i,
    input  host_wr_ready_o, host_wr_err_o,
    input  config_mem_read_data_o, config_mem_read_ack_o, config_mem_read_err_o,
    input  npu_capability_o, in_pipeline_cim_capability_o,
    input  valid_words_o, state_o
  );
endinterface

// File: rtl/config_word_ram.sv
// Config word storage: DEPTH x 32, one write port, one read port,
// synchronous (registered) read, no reset on contents or read data.
//   clk_i      clock
//   wr_en_i    write strobe, wr_addr_i / wr_data_i
//   rd_en_i    read strobe, rd_addr_i; rd_data_o valid the next cycle
module config_word_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem_reg [DEPTH];
  logic [31:0] rd_data_reg;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_reg[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_reg <= mem_reg[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_reg;

endmodule

// File: rtl/model_config_mem.sv
// Model configuration memory.
// The host fills a word array (EMPTY -> LOADING), commits it (LOADING ->
// READY, capability words latched) and later unlocks it (READY -> EMPTY).
// The scheduler reads words with a fixed one-cycle latency; reads are only
// successful in READY and below the highest written index plus one.
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    model_config_mem_if.slave (host write, control, scheduler read,
//          status outputs)
module model_config_mem
  import model_config_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  model_config_mem_if.slave  bus
);

  logic [1:0]    state_reg, state_next, state_cur;
  logic [AW:0]   valid_words_reg;
  logic          wr_err_reg;
  logic          rd_ack_reg;
  logic          rd_err_reg;
  logic [31:0]   cap_reg  [NUM_CAPS];
  logic [31:0]   cap_word [NUM_CAPS];

  logic          wr_accept, wr_in_range, wr_store;
  logic [AW-1:0] wr_idx;
  logic [AW:0]   wr_extent;
  logic          commit_fire, unlock_fire;
  logic          rd_ok;
  logic [31:0]   ram_rd_data;

  assign state_cur = decode_state(state_reg);

  // Writes stall (not drop) while READY; nothing is taken during reset.
  assign wr_accept   = bus.host_wr_valid_i && (state_cur != ST_READY) && !rst_i;
  assign wr_in_range = (bus.host_wr_addr_i[31:AW] == '0);
  assign wr_store    = wr_accept && wr_in_range;
  assign wr_idx      = bus.host_wr_addr_i[AW-1:0];
  assign wr_extent   = {1'b0, wr_idx} + (AW+1)'(1);

  assign commit_fire = bus.host_commit_i && (state_cur == ST_LOADING);
  assign unlock_fire = bus.host_unlock_i && (state_cur == ST_READY);

  // Read outcome is decided from the state at request time, so a read in
  // the unlock cycle still sees READY and a read in the commit cycle does not.
  assign rd_ok = (state_cur == ST_READY) &&
                 (bus.config_mem_addr_i < 32'(valid_words_reg));

  config_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_en_i   (wr_store),
    .wr_addr_i (wr_idx),
    .wr_data_i (bus.host_wr_data_i),
    .rd_en_i   (bus.config_mem_read_valid_i && rd_ok && !rst_i),
    .rd_addr_i (bus.config_mem_addr_i[AW-1:0]),
    .rd_data_o (ram_rd_data)
  );

  // Capability words are mirrored in registers as they are written so the
  // commit can latch them without a second RAM read port. A write to the
  // same word in the commit cycle is forwarded. The mirrors follow the array
  // exactly: neither is cleared by reset or unlock.
  for (genvar gi = 0; gi < NUM_CAPS; gi++) begin : g_cap
    localparam int unsigned WORD_IDX = (gi == 0) ? CAP_NPU_IDX : CAP_CIM_IDX;
    logic [31:0] shadow_reg;
    logic        hit;

    assign hit = wr_store && (wr_idx == AW'(WORD_IDX));

    always_ff @(posedge clk_i) begin
      if (hit) begin
        shadow_reg <= bus.host_wr_data_i;
      end
    end

    assign cap_word[gi] = hit ? bus.host_wr_data_i : shadow_reg;
  end

  always_comb begin
    state_next = state_cur;
    case (state_cur)
      ST_EMPTY:   if (wr_accept)   state_next = ST_LOADING;
      ST_LOADING: if (commit_fire) state_next = ST_READY;
      ST_READY:   if (unlock_fire) state_next = ST_EMPTY;
      default:                     state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= ST_EMPTY;
      valid_words_reg <= '0;
      wr_err_reg      <= 1'b0;
      rd_ack_reg      <= 1'b0;
      rd_err_reg      <= 1'b0;
      for (int i = 0; i < NUM_CAPS; i++) begin
        cap_reg[i] <= '0;
      end
    end else begin
      state_reg  <= state_next;
      wr_err_reg <= wr_accept && !wr_in_range;
      rd_ack_reg <= bus.config_mem_read_valid_i;
      rd_err_reg <= bus.config_mem_read_valid_i && !rd_ok;

      if (unlock_fire) begin
        valid_words_reg <= '0;
      end else if (wr_store && (wr_extent > valid_words_reg)) begin
        valid_words_reg <= wr_extent;
      end

      for (int i = 0; i < NUM_CAPS; i++) begin
        if (commit_fire) begin
          cap_reg[i] <= cap_word[i];
        end else if (unlock_fire) begin
          cap_reg[i] <= '0;
        end
      end
    end
  end

  // While rst_i is high every output already shows its reset value, so a
  // read response that was in flight when reset arrived never appears.
  assign bus.host_wr_ready_o              = wr_accept;
  assign bus.host_wr_err_o                = wr_err_reg && !rst_i;
  assign bus.config_mem_read_ack_o        = rd_ack_reg && !rst_i;
  assign bus.config_mem_read_err_o        = rd_err_reg && !rst_i;
  assign bus.config_mem_read_data_o       = (rd_ack_reg && !rd_err_reg && !rst_i) ?
                                            ram_rd_data : 32'd0;
  assign bus.npu_capability_o             = rst_i ? 32'd0 : cap_reg[CAP_NPU_IDX];
  assign bus.in_pipeline_cim_capability_o = rst_i ? 32'd0 : cap_reg[CAP_CIM_IDX];
  assign bus.valid_words_o                = rst_i ? '0 : valid_words_reg;
  assign bus.state_o                      = rst_i ? ST_EMPTY : state_cur;

endmodule
